ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/ram_arb_rr_pick.sv | 29 ++
 rtl/ram_port_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared definitions for the two-requester RAM port arbiter.
//               Holds the arbitration FSM state encoding, the default
//               address/data widths, the default burst cap and the width
//               of the burst counter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int c_DEF_AW        = 8;
    localparam int c_DEF_DW        = 8;
    localparam int c_DEF_MAX_BURST = 4;
    localparam int c_CNT_W         = 4;

    // IDLE  : no owner, new grants chosen by the priority picker
    // OWN_A : requester A holds the port for a locked burst
    // OWN_B : requester B holds the port for a locked burst
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_e;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_rr_pick
// Description : Two-way priority selector. Grants the single valid
//               requester, or the one named by i_prio when both are valid.
// Ports       : i_a_valid - requester A valid
//               i_b_valid - requester B valid
//               i_prio    - preferred requester on contention (0=A, 1=B)
//               o_grant   - one-hot grant, bit 0 = A, bit 1 = B
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_rr_pick (
    input  logic       i_a_valid,
    input  logic       i_b_valid,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_a_valid && (!i_b_valid || !i_prio)) begin
            o_grant[0] = 1'b1;
        end else if (i_b_valid) begin
            o_grant[1] = 1'b1;
        end
    end

endmodule : ram_arb_rr_pick
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one single-port RAM (1-cycle registered read) between
//               two requesters A and B. Round-robin arbitration when both
//               contend; a requester asserting lock keeps ownership for up to
//               MAX_BURST consecutive transfers.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               a_valid/a_we/a_lock   - A request, write strobe, lock hint
//               a_addr/a_wdata        - A address and write data
//               a_ready               - A grant (transfer when valid&ready)
//               a_rvalid/a_rdata      - A read response, one cycle after grant
//               b_*                   - identical set for requester B
//               ram_en/ram_we         - RAM port enable and write strobe
//               ram_addr/ram_wdata    - RAM port address and write data
//               ram_rdata             - RAM read data (registered in the RAM)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW        = c_DEF_AW,
    parameter int DW        = c_DEF_DW,
    parameter int MAX_BURST = c_DEF_MAX_BURST
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_valid,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ready,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_valid,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ready,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    // One extra bit so count+1 never wraps before the compare.
    localparam logic [c_CNT_W:0] c_MAX_BURST = (c_CNT_W+1)'(MAX_BURST);
    localparam logic [c_CNT_W:0] c_ONE       = (c_CNT_W+1)'(1);

    arb_state_e         r_state_q, w_state_d;
    logic               r_prio_q,  w_prio_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic               r_a_rvalid_q, w_a_rvalid_d;
    logic               r_b_rvalid_q, w_b_rvalid_d;

    logic [1:0]         w_pick;
    logic               w_a_grant;
    logic               w_b_grant;
    logic               w_a_xfer;
    logic               w_b_xfer;
    logic               w_xfer_lock;
    logic [c_CNT_W:0]   w_cnt_inc;

    ram_arb_rr_pick u_pick (
        .i_a_valid (a_valid),
        .i_b_valid (b_valid),
        .i_prio    (r_prio_q),
        .o_grant   (w_pick)
    );

    // Grants depend only on valids and registered state, never on the
    // request payload, so ready cannot form a loop through address/data.
    always_comb begin
        w_a_grant = 1'b0;
        w_b_grant = 1'b0;
        if (!rst) begin
            case (r_state_q)
                IDLE: begin
                    w_a_grant = w_pick[0];
                    w_b_grant = w_pick[1];
                end
                OWN_A:   w_a_grant = a_valid;
                OWN_B:   w_b_grant = b_valid;
                default: ;
            endcase
        end
    end

    assign a_ready  = w_a_grant;
    assign b_ready  = w_b_grant;
    assign w_a_xfer = a_valid & w_a_grant;
    assign w_b_xfer = b_valid & w_b_grant;

    assign w_xfer_lock = w_a_xfer ? a_lock : b_lock;
    assign w_cnt_inc   = {1'b0, r_cnt_q} + c_ONE;

    // Next-state: the burst count is always zero in IDLE, so a locked grant
    // from IDLE and a continuing locked transfer share the same rule.
    always_comb begin
        w_state_d    = r_state_q;
        w_prio_d     = r_prio_q;
        w_cnt_d      = r_cnt_q;
        w_a_rvalid_d = w_a_xfer & ~a_we;
        w_b_rvalid_d = w_b_xfer & ~b_we;

        if (w_a_xfer || w_b_xfer) begin
            if (w_xfer_lock && (w_cnt_inc < c_MAX_BURST)) begin
                w_state_d = w_a_xfer ? OWN_A : OWN_B;
                w_cnt_d   = w_cnt_inc[c_CNT_W-1:0];
            end else begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
                // Hand priority to the requester that did not transfer.
                w_prio_d  = w_a_xfer;
            end
        end else if (r_state_q == OWN_A) begin
            // Owner went idle: release the port.
            w_state_d = IDLE;
            w_cnt_d   = '0;
            w_prio_d  = 1'b1;
        end else if (r_state_q == OWN_B) begin
            w_state_d = IDLE;
            w_cnt_d   = '0;
            w_prio_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= IDLE;
            r_prio_q     <= 1'b0;
            r_cnt_q      <= '0;
            r_a_rvalid_q <= 1'b0;
            r_b_rvalid_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_prio_q     <= w_prio_d;
            r_cnt_q      <= w_cnt_d;
            r_a_rvalid_q <= w_a_rvalid_d;
            r_b_rvalid_q <= w_b_rvalid_d;
        end
    end

    // A response due in the first reset cycle is suppressed here, since the
    // registered flag only clears on the reset edge itself.
    assign a_rvalid = r_a_rvalid_q & ~rst;
    assign b_rvalid = r_b_rvalid_q & ~rst;
    assign a_rdata  = a_rvalid ? ram_rdata : '0;
    assign b_rdata  = b_rvalid ? ram_rdata : '0;

    assign ram_en    = w_a_xfer | w_b_xfer;
    assign ram_we    = (w_a_xfer & a_we) | (w_b_xfer & b_we);
    assign ram_addr  = w_b_xfer ? b_addr  : (w_a_xfer ? a_addr  : '0);
    assign ram_wdata = w_b_xfer ? b_wdata : (w_a_xfer ? a_wdata : '0);

endmodule : ram_port_arbiter
`default_nettype wire
